// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the SPI command stream and
// a local host port. SPI has strict priority and cannot be stalled, so a
// 1-entry buffer absorbs SPI commands while the RAM is busy with something
// else. SPI address shadows plus dirty flags restore the SPI's view of the
// RAM address registers after the host has overwritten them.
module ram_arbiter #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] spi_rx_data,
    input  logic                 spi_rx_valid,
    output logic [ADDR_SIZE-1:0] spi_tx_data,
    output logic                 spi_tx_valid,
    input  logic                 host_req,
    input  logic                 host_wr,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [ADDR_SIZE-1:0] host_wdata,
    output logic                 host_gnt,
    output logic [ADDR_SIZE-1:0] host_rdata,
    output logic                 host_rvalid,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid,
    output logic                 overrun
);
    localparam int CW = ADDR_SIZE + 2;

    localparam logic [1:0] OP_WA = 2'b00;
    localparam logic [1:0] OP_WD = 2'b01;
    localparam logic [1:0] OP_RA = 2'b10;
    localparam logic [1:0] OP_RD = 2'b11;

    typedef enum logic [1:0] {IDLE, SPI_RESTORE, H_ADDR, H_DATA} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        buf_q, buf_d;
    logic                 buf_vld_q, buf_vld_d;
    logic [ADDR_SIZE-1:0] wr_sh_q, wr_sh_d;
    logic [ADDR_SIZE-1:0] rd_sh_q, rd_sh_d;
    logic                 wr_dirty_q, wr_dirty_d;
    logic                 rd_dirty_q, rd_dirty_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 rd_owner_q, rd_owner_d;   // 1 = SPI owns the pending read
    logic                 overrun_q, overrun_d;
    logic [CW-1:0]        ram_din_q, ram_din_d;
    logic                 ram_rx_valid_q, ram_rx_valid_d;
    logic                 host_gnt_q, host_gnt_d;

    // Issue bookkeeping shared by all states
    logic                 iss_en;
    logic                 iss_spi;
    logic [CW-1:0]        iss_cmd;
    logic [1:0]           iss_op;
    logic                 buf_drain;
    logic                 live_taken;
    logic                 cand_vld;
    logic [CW-1:0]        cand;
    logic [1:0]           cand_op;

    // State, arbitration and per-command side effects
    always_comb begin
        state_d        = state_q;
        buf_d          = buf_q;
        buf_vld_d      = buf_vld_q;
        wr_sh_d        = wr_sh_q;
        rd_sh_d        = rd_sh_q;
        wr_dirty_d     = wr_dirty_q;
        rd_dirty_d     = rd_dirty_q;
        rd_pend_d      = rd_pend_q;
        rd_owner_d     = rd_owner_q;
        overrun_d      = overrun_q;
        ram_din_d      = ram_din_q;
        ram_rx_valid_d = 1'b0;
        host_gnt_d     = 1'b0;
        iss_en         = 1'b0;
        iss_spi        = 1'b0;
        iss_cmd        = '0;
        buf_drain      = 1'b0;
        live_taken     = 1'b0;
        cand_vld       = buf_vld_q | spi_rx_valid;
        cand           = buf_vld_q ? buf_q : spi_rx_data;
        cand_op        = cand[CW-1 -: 2];

        case (state_q)
            IDLE: begin
                if (cand_vld) begin
                    // An SPI read data command waits while another read is outstanding
                    if (!(cand_op == OP_RD && rd_pend_q)) begin
                        if ((cand_op == OP_WD && wr_dirty_q) || (cand_op == OP_RD && rd_dirty_q)) begin
                            // Host clobbered the SPI address: replay it first, cmd stays buffered
                            iss_en  = 1'b1;
                            iss_spi = 1'b1;
                            iss_cmd = (cand_op == OP_WD) ? {OP_WA, wr_sh_q} : {OP_RA, rd_sh_q};
                            state_d = SPI_RESTORE;
                        end else begin
                            iss_en  = 1'b1;
                            iss_spi = 1'b1;
                            iss_cmd = cand;
                            if (buf_vld_q) buf_drain  = 1'b1;
                            else           live_taken = 1'b1;
                        end
                    end
                end else if (host_req && (host_wr || !rd_pend_q)) begin
                    iss_en  = 1'b1;
                    iss_cmd = {(host_wr ? OP_WA : OP_RA), host_addr};
                    state_d = H_ADDR;
                end
            end
            SPI_RESTORE: begin
                iss_en    = 1'b1;
                iss_spi   = 1'b1;
                iss_cmd   = buf_q;
                buf_drain = 1'b1;
                state_d   = IDLE;
            end
            H_ADDR: begin
                iss_en     = 1'b1;
                iss_cmd    = host_wr ? {OP_WD, host_wdata} : {OP_RD, {ADDR_SIZE{1'b0}}};
                host_gnt_d = 1'b1;
                state_d    = H_DATA;
            end
            H_DATA: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        iss_op = iss_cmd[CW-1 -: 2];

        if (ram_tx_valid) rd_pend_d = 1'b0;

        if (iss_en) begin
            ram_rx_valid_d = 1'b1;
            ram_din_d      = iss_cmd;
            if (iss_spi) begin
                // Restores go through here too: same shadow, flag cleared
                if (iss_op == OP_WA) begin
                    wr_sh_d    = iss_cmd[ADDR_SIZE-1:0];
                    wr_dirty_d = 1'b0;
                end
                if (iss_op == OP_RA) begin
                    rd_sh_d    = iss_cmd[ADDR_SIZE-1:0];
                    rd_dirty_d = 1'b0;
                end
            end else begin
                if (iss_op == OP_WA) wr_dirty_d = 1'b1;
                if (iss_op == OP_RA) rd_dirty_d = 1'b1;
            end
            if (iss_op == OP_RD) begin
                rd_pend_d  = 1'b1;
                rd_owner_d = iss_spi;
            end
        end

        // Buffer: drained entry frees the slot for a live command in the same cycle
        if (buf_drain) buf_vld_d = 1'b0;
        if (spi_rx_valid && !live_taken) begin
            if (buf_vld_q && !buf_drain) begin
                overrun_d = 1'b1;
            end else begin
                buf_d     = spi_rx_data;
                buf_vld_d = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            buf_q          <= '0;
            buf_vld_q      <= 1'b0;
            wr_sh_q        <= '0;
            rd_sh_q        <= '0;
            wr_dirty_q     <= 1'b0;
            rd_dirty_q     <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_owner_q     <= 1'b0;
            overrun_q      <= 1'b0;
            ram_din_q      <= '0;
            ram_rx_valid_q <= 1'b0;
            host_gnt_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            buf_q          <= buf_d;
            buf_vld_q      <= buf_vld_d;
            wr_sh_q        <= wr_sh_d;
            rd_sh_q        <= rd_sh_d;
            wr_dirty_q     <= wr_dirty_d;
            rd_dirty_q     <= rd_dirty_d;
            rd_pend_q      <= rd_pend_d;
            rd_owner_q     <= rd_owner_d;
            overrun_q      <= overrun_d;
            ram_din_q      <= ram_din_d;
            ram_rx_valid_q <= ram_rx_valid_d;
            host_gnt_q     <= host_gnt_d;
        end
    end

    assign ram_din      = ram_din_q;
    assign ram_rx_valid = ram_rx_valid_q;
    assign host_gnt     = host_gnt_q;
    assign overrun      = overrun_q;

    // Read return is routed combinationally to whoever issued the last 11
    assign spi_tx_data  = ram_dout;
    assign host_rdata   = ram_dout;
    assign spi_tx_valid = ram_tx_valid & rd_owner_q;
    assign host_rvalid  = ram_tx_valid & ~rd_owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, command/readback monitors, a vector
// table of direct SPI commands, hand sequences for the multi-cycle cases and
// a randomized phase checked against an address-partitioned memory model.
module tb_ram_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] spi_rx_data;
    logic       spi_rx_valid;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid;
    logic       host_req, host_wr;
    logic [7:0] host_addr, host_wdata;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int gnt_cnt = 0;

    logic [9:0] cmdq[$];
    logic [9:0] expc[$];
    logic [7:0] spi_expq[$];
    logic [7:0] host_expq[$];

    logic [7:0] mem [256];
    logic [7:0] gm  [256];
    logic [7:0] m_waddr, m_raddr;

    typedef struct {
        logic [9:0] cmd;
        logic       rd;
        logic [7:0] rdv;
    } vec_t;
    vec_t tbl[8];

    ram_arbiter #(.ADDR_SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Behavioural single-port RAM, 1-cycle read latency, cleared by reset
    always @(posedge clk) begin
        if (!rst_n) begin
            ram_tx_valid <= 1'b0;
            ram_dout     <= 8'h00;
            m_waddr      <= 8'h00;
            m_raddr      <= 8'h00;
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else begin
            ram_tx_valid <= 1'b0;
            if (ram_rx_valid) begin
                case (ram_din[9:8])
                    2'b00: m_waddr <= ram_din[7:0];
                    2'b01: mem[m_waddr] <= ram_din[7:0];
                    2'b10: m_raddr <= ram_din[7:0];
                    default: begin
                        ram_tx_valid <= 1'b1;
                        ram_dout     <= mem[m_raddr];
                    end
                endcase
            end
        end
    end

    // Monitors: RAM command log, gnt count, readback scoreboards
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_rx_valid) cmdq.push_back(ram_din);
            if (host_gnt) gnt_cnt++;
            if (spi_tx_valid && host_rvalid) chk("both_rvalid", 1, 0);
            if (spi_tx_valid) begin
                if (spi_expq.size() == 0) chk("spi_rd_unexpected", 1, 0);
                else chk("spi_rdata", spi_tx_data, spi_expq.pop_front());
            end
            if (host_rvalid) begin
                if (host_expq.size() == 0) chk("host_rd_unexpected", 1, 0);
                else chk("host_rdata", host_rdata, host_expq.pop_front());
            end
        end
    end

    task automatic spi_send(input logic [9:0] c);
        @(posedge clk); #1;
        spi_rx_data  = c;
        spi_rx_valid = 1'b1;
        @(posedge clk); #1;
        spi_rx_valid = 1'b0;
    endtask

    task automatic host_txn(input logic wr, input logic [7:0] a, input logic [7:0] d, output int lat);
        @(posedge clk); #1;
        host_req = 1'b1; host_wr = wr; host_addr = a; host_wdata = d;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (host_gnt) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) chk("host_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    task automatic cmp_cmds(input string nm);
        chk({nm, "_count"}, cmdq.size(), expc.size());
        for (int i = 0; i < expc.size() && i < cmdq.size(); i++)
            chk(nm, cmdq[i], expc[i]);
        cmdq.delete();
        expc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int lat, g0;
        rst_n = 1'b0; spi_rx_data = '0; spi_rx_valid = 1'b0;
        host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;

        // Reset values
        idle(3);
        @(negedge clk);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_ram_rx_valid", ram_rx_valid, 0);
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_spi_tx_valid", spi_tx_valid, 0);
        chk("rst_host_rvalid", host_rvalid, 0);
        rst_n = 1'b1;
        idle(2);

        // Vector table: direct SPI issue, 1-cycle latency, 0 added read latency
        tbl[0] = '{10'h005, 1'b0, 8'h00};
        tbl[1] = '{10'h13C, 1'b0, 8'h00};
        tbl[2] = '{10'h205, 1'b0, 8'h00};
        tbl[3] = '{10'h300, 1'b1, 8'h3C};
        tbl[4] = '{10'h010, 1'b0, 8'h00};
        tbl[5] = '{10'h15A, 1'b0, 8'h00};
        tbl[6] = '{10'h210, 1'b0, 8'h00};
        tbl[7] = '{10'h300, 1'b1, 8'h5A};
        for (int k = 0; k < 8; k++) begin
            if (tbl[k].rd) spi_expq.push_back(tbl[k].rdv);
            @(posedge clk); #1;
            spi_rx_data = tbl[k].cmd; spi_rx_valid = 1'b1;
            @(negedge clk);
            chk("vec_pre_valid", ram_rx_valid, 0);
            @(posedge clk); #1;
            spi_rx_valid = 1'b0;
            @(negedge clk);
            chk("vec_valid", ram_rx_valid, 1);
            chk("vec_din", ram_din, tbl[k].cmd);
            @(negedge clk);
            chk("vec_rd_latency", spi_tx_valid, tbl[k].rd);
            idle(2);
        end
        chk("vec_spi_q_empty", spi_expq.size(), 0);
        cmdq.delete();

        // Host write then host read
        g0 = gnt_cnt;
        host_txn(1'b1, 8'h12, 8'h3C, lat);
        chk("host_gnt_latency", lat, 3);
        host_expq.push_back(8'h3C);
        host_txn(1'b0, 8'h12, 8'h00, lat);
        idle(4);
        chk("host_gnt_pulses", gnt_cnt - g0, 2);
        chk("host_rd_done", host_expq.size(), 0);
        expc = '{10'h012, 10'h13C, 10'h212, 10'h300};
        cmp_cmds("t1_cmds");

        // SPI write address restored after host write
        spi_send(10'h005);
        host_txn(1'b1, 8'h40, 8'h99, lat);
        spi_send(10'h1AA);
        idle(6);
        expc = '{10'h005, 10'h040, 10'h199, 10'h005, 10'h1AA};
        cmp_cmds("t2_cmds");
        chk("t2_mem05", mem[8'h05], 8'hAA);

        // SPI read address restored after host read; each read routed to its owner
        spi_send(10'h205);
        host_expq.push_back(8'h99);
        host_txn(1'b0, 8'h40, 8'h00, lat);
        spi_expq.push_back(8'hAA);
        spi_send(10'h300);
        idle(6);
        expc = '{10'h205, 10'h240, 10'h300, 10'h205, 10'h300};
        cmp_cmds("t3_cmds");
        chk("t3_spi_q_empty", spi_expq.size(), 0);
        chk("t3_host_q_empty", host_expq.size(), 0);

        // SPI arrives as host enters H_ADDR: buffered, issued from first IDLE
        @(posedge clk); #1;
        host_req = 1'b1; host_wr = 1'b1; host_addr = 8'h50; host_wdata = 8'h77;
        @(posedge clk); #1;
        spi_rx_data = 10'h221; spi_rx_valid = 1'b1;
        @(negedge clk);
        chk("t4_addr_cmd", ram_din, 10'h050);
        @(posedge clk); #1;
        spi_rx_valid = 1'b0;
        @(negedge clk);
        chk("t4_gnt", host_gnt, 1);
        chk("t4_data_cmd", ram_din, 10'h177);
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        chk("t4_idle_quiet", ram_rx_valid, 0);
        @(negedge clk);
        chk("t4_buf_valid", ram_rx_valid, 1);
        chk("t4_buf_cmd", ram_din, 10'h221);
        idle(3);
        expc = '{10'h050, 10'h177, 10'h221};
        cmp_cmds("t4_cmds");

        // Buffer full during host transaction: second SPI cmd dropped
        chk("t5_overrun_before", overrun, 0);
        @(posedge clk); #1;
        host_req = 1'b1; host_wr = 1'b1; host_addr = 8'h60; host_wdata = 8'h11;
        @(posedge clk); #1;
        spi_rx_data = 10'h033; spi_rx_valid = 1'b1;
        @(posedge clk); #1;
        spi_rx_data = 10'h044;
        @(posedge clk); #1;
        spi_rx_valid = 1'b0; host_req = 1'b0;
        idle(3);
        @(negedge clk);
        chk("t5_overrun_set", overrun, 1);
        idle(5);
        @(negedge clk);
        chk("t5_overrun_sticky", overrun, 1);
        expc = '{10'h060, 10'h111, 10'h033};
        cmp_cmds("t5_cmds");

        // Reset during H_DATA
        g0 = gnt_cnt;
        @(posedge clk); #1;
        host_req = 1'b1; host_wr = 1'b1; host_addr = 8'h70; host_wdata = 8'h22;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_ram_din", ram_din, 0);
        chk("t6_ram_rx_valid", ram_rx_valid, 0);
        chk("t6_host_gnt", host_gnt, 0);
        chk("t6_overrun", overrun, 0);
        chk("t6_rvalids", {spi_tx_valid, host_rvalid}, 0);
        host_req = 1'b0;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        cmdq.delete();
        idle(4);
        chk("t6_no_gnt", gnt_cnt - g0, 0);
        @(posedge clk); #1;
        spi_rx_data = 10'h007; spi_rx_valid = 1'b1;
        @(posedge clk); #1;
        spi_rx_valid = 1'b0;
        @(negedge clk);
        chk("t6_idle_issue", {ram_rx_valid, ram_din}, {1'b1, 10'h007});
        idle(2);
        cmdq.delete();

        // Randomized: SPI owns 0x00-0x7F, host owns 0x80-0xFF
        for (int i = 0; i < 256; i++) gm[i] = 8'h00;
        fork
            begin
                logic [7:0] sw, sr, p;
                logic [1:0] op;
                sw = 8'($urandom_range(0, 127));
                sr = 8'($urandom_range(0, 127));
                spi_send({2'b00, sw});
                idle(8);
                spi_send({2'b10, sr});
                idle(8);
                for (int n = 0; n < 80; n++) begin
                    op = 2'($urandom_range(0, 3));
                    p  = (op[0] == 1'b0) ? 8'($urandom_range(0, 127)) : 8'($urandom);
                    case (op)
                        2'b00: sw = p;
                        2'b01: gm[sw] = p;
                        2'b10: sr = p;
                        default: begin
                            p = 8'h00;
                            spi_expq.push_back(gm[sr]);
                        end
                    endcase
                    spi_send({op, p});
                    idle($urandom_range(8, 12));
                end
            end
            begin
                logic w;
                logic [7:0] a, d;
                int hl;
                for (int n = 0; n < 50; n++) begin
                    w = 1'($urandom_range(0, 1));
                    a = 8'h80 | 8'($urandom_range(0, 127));
                    d = 8'($urandom);
                    if (w) gm[a] = d;
                    else host_expq.push_back(gm[a]);
                    host_txn(w, a, d, hl);
                    idle($urandom_range(0, 3));
                end
            end
        join
        idle(10);
        chk("rnd_spi_q_empty", spi_expq.size(), 0);
        chk("rnd_host_q_empty", host_expq.size(), 0);
        chk("rnd_overrun", overrun, 0);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== gm[i]) bad++;
            chk("rnd_mem_final", bad, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port RAM between the SPI slave command stream and a local host port. It sits between the SPI slave's rx/tx interface and the RAM's Din/rx_valid/Dout/tx_valid interface. It issues the RAM's 2-bit-opcode command format on behalf of both requesters and never lets one requester corrupt the other's address. SPI has strict priority because it cannot be stalled; the host uses a req/gnt handshake.

## Interface
- ADDR_SIZE, 8, RAM address and data width; command word is ADDR_SIZE+2 bits, opcode in the top 2 bits (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- spi_rx_data  in  ADDR_SIZE+2  command from SPI slave.
- spi_rx_valid  in  1  one-cycle strobe qualifying spi_rx_data.
- spi_tx_data  out  ADDR_SIZE  read data to SPI slave.
- spi_tx_valid  out  1  read data strobe to SPI slave.
- host_req  in  1  host transaction request, held until host_gnt.
- host_wr  in  1  1 = write, 0 = read; stable while host_req.
- host_addr  in  ADDR_SIZE  host address; stable while host_req.
- host_wdata  in  ADDR_SIZE  host write data; stable while host_req.
- host_gnt  out  1  one-cycle pulse: host command fully issued.
- host_rdata  out  ADDR_SIZE  read data to host.
- host_rvalid  out  1  read data strobe to host.
- ram_din  out  ADDR_SIZE+2  command to RAM.
- ram_rx_valid  out  1  command strobe to RAM.
- ram_dout  in  ADDR_SIZE  RAM read data.
- ram_tx_valid  in  1  RAM read data strobe.
- overrun  out  1  sticky: SPI command dropped; cleared only by reset.

## Operation
- FSM states: IDLE, SPI_RESTORE, H_ADDR, H_DATA. Reset -> IDLE.
- 1-entry SPI buffer. A spi_rx_valid is issued directly only in IDLE with the buffer empty. In every other case it is written to the buffer. If the buffer is already full, the command is dropped and overrun is set.
- Shadows: spi_wr_addr and spi_rd_addr capture the payload of every SPI 00 and 10 command. Dirty flags: wr_dirty is set when the host issues 00 and rd_dirty is set when the host issues 10. SPI 00 clears wr_dirty and SPI 10 clears rd_dirty. The same flags are cleared by a restore.
- IDLE priority: buffered SPI cmd, then live SPI cmd, then host_req. A live cmd that arrives while the buffer is being issued goes into the buffer.
- SPI cmd 01 with wr_dirty set, or 11 with rd_dirty set: the cmd is held in the buffer and the FSM goes to SPI_RESTORE. SPI_RESTORE issues 00/spi_wr_addr or 10/spi_rd_addr, clears the flag and returns to IDLE, where the buffered cmd is then issued.
- Host write: H_ADDR issues 00/host_addr, then H_DATA issues 01/host_wdata with host_gnt=1, then IDLE.
- Host read: H_ADDR issues 10/host_addr, then H_DATA issues 11/0 with host_gnt=1, then IDLE.
- Read owner: issuing any 11 sets rd_owner (SPI or host) and rd_pend. rd_pend is cleared by ram_tx_valid.
- While rd_pend=1, no 11 is issued: a host read waits in IDLE and an SPI 11 waits in the buffer.
- Return routing is combinational: spi_tx_data = host_rdata = ram_dout. spi_tx_valid = ram_tx_valid & owner SPI. host_rvalid = ram_tx_valid & owner host.
- A host transaction is never interrupted once H_ADDR is entered.
- Reset mid-operation: FSM goes to IDLE, the buffer is emptied, flags, shadows and rd_pend are cleared, and the in-flight host transaction is abandoned with no gnt.

## Timing
- Reset values: ram_din=0, ram_rx_valid=0, host_gnt=0, overrun=0. spi_tx_valid and host_rvalid are 0 as long as ram_tx_valid is 0.
- ram_din, ram_rx_valid and host_gnt are registered.
- Live SPI cmd at cycle N in IDLE: ram_rx_valid is high in N+1.
- SPI cmd that needs a restore, at cycle N: restore command in N+1, SPI cmd in N+2.
- host_req seen at N in IDLE: address command in N+1, data command and host_gnt in N+2. If host_req is still high in the following IDLE cycle, a new transaction starts.
- Read data latency is the RAM's latency (1 cycle after the 11 command); the arbiter adds 0.
- ram_rx_valid is never high on two commands from different owners in one cycle.

## Test plan
- Host write 0x3C to addr 0x12, then host read of 0x12: RAM sees 00/12, 01/3C, 10/12, 11/00; host_rvalid=1 with host_rdata=0x3C; host_gnt pulses twice.
- SPI 00/0x05, then host write to 0x40, then SPI 01/0xAA: RAM sees 00/05, 00/40, 01/xx, then 00/05 restore, then 01/AA; mem[0x05]=0xAA.
- SPI 10/0x05, then host read of 0x40, then SPI 11: restore 10/05 precedes 11; only spi_tx_valid fires, with data 0xAA.
- spi_rx_valid arrives in the same cycle the host enters H_ADDR: the SPI cmd is buffered, the host completes, and the SPI cmd is issued in the first IDLE cycle.
- Two SPI cmds while the buffer is full during H_DATA: the second is dropped and overrun=1 until rst_n.
- rst_n asserted during H_DATA: all outputs are 0 immediately, no host_gnt, and the FSM is in IDLE after release.
